// File: rtl/iot_event_arbiter.sv
// iot_event_arbiter
//   Buffers one connect/disconnect event per device gateway and issues them
//   to the active-devices monitor one per cycle, round-robin. A shadow of the
//   monitor's 8-bit count refuses events that would overflow past
//   MAX_DEVICES or underflow below zero.
//
// Parameters
//   ID_W        requester index width, N_REQ = 2**ID_W
//   MAX_DEVICES upper bound on the active count (1..255)
//
// Build option
//   ARB_FIXED_PRIORITY_EN  when defined, the lowest pending index always wins
//                          and last_grant no longer steers selection.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   freeze        blocks grants; capture continues
//   req_valid     per-requester event valid
//   req_dir       per-requester direction (1 = connect, 0 = disconnect)
//   req_ready     per-requester ready (= ~pending)
//   change        registered one-cycle pulse per issued event
//   on_off        registered direction of the last issued event
//   grant_id      registered index of the last granted requester
//   reject        registered one-cycle pulse when a granted event is refused
//   active_count  shadow of the monitor count
//   busy          any event pending
module iot_event_arbiter #(
  parameter int ID_W        = 2,
  parameter int MAX_DEVICES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic [2**ID_W-1:0]    req_valid,
  input  logic [2**ID_W-1:0]    req_dir,
  output logic [2**ID_W-1:0]    req_ready,
  output logic                  change,
  output logic                  on_off,
  output logic [ID_W-1:0]       grant_id,
  output logic                  reject,
  output logic [7:0]            active_count,
  output logic                  busy
);

  localparam int N_REQ = 2**ID_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_FROZEN
  } ctrl_e;

  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] pdir_q, pdir_d;
  logic [N_REQ-1:0] capture;
  logic [N_REQ-1:0] grant_mask;
  logic [ID_W-1:0]  last_grant_q;
  logic [ID_W-1:0]  grant_id_q;
  logic             change_q, reject_q, on_off_q;
  logic [7:0]       count_q;

  ctrl_e            state;
  logic             grant;
  logic             found;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  idx;
  logic             win_dir;
  logic             refuse;

  // Control state is a pure decode of freeze and busy; it carries no history.
  always_comb begin
    if (freeze)
      state = ST_FROZEN;
    else if (|pending_q)
      state = ST_ARB;
    else
      state = ST_IDLE;
  end

  // Winner search over the pending flags.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      idx = ID_W'(k);
`else
      // Index arithmetic wraps naturally at N_REQ = 2**ID_W.
      idx = last_grant_q + ID_W'(k + 1);
`endif
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant      = (state == ST_ARB) && found;
  assign grant_mask = grant ? (N_REQ'(1) << win) : '0;
  assign win_dir    = pdir_q[win];
  assign refuse     = win_dir ? (count_q == 8'(MAX_DEVICES)) : (count_q == 8'd0);

  // The winner's ready was low, so capture and clear never hit the same bit.
  assign capture   = req_valid & ~pending_q;
  assign pending_d = (pending_q | capture) & ~grant_mask;
  assign pdir_d    = (pdir_q & ~capture) | (req_dir & capture);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      pdir_q       <= '0;
      last_grant_q <= '1;
      grant_id_q   <= '0;
      change_q     <= 1'b0;
      reject_q     <= 1'b0;
      on_off_q     <= 1'b1;
      count_q      <= '0;
    end else begin
      pending_q <= pending_d;
      pdir_q    <= pdir_d;
      change_q  <= 1'b0;
      reject_q  <= 1'b0;
      if (grant) begin
        last_grant_q <= win;
        grant_id_q   <= win;
        if (refuse) begin
          reject_q <= 1'b1;
        end else begin
          change_q <= 1'b1;
          on_off_q <= win_dir;
          count_q  <= win_dir ? count_q + 8'd1 : count_q - 8'd1;
        end
      end
    end
  end

  assign req_ready    = ~pending_q;
  assign busy         = |pending_q;
  assign change       = change_q;
  assign reject       = reject_q;
  assign on_off       = on_off_q;
  assign grant_id     = grant_id_q;
  assign active_count = count_q;

endmodule

// File: tb/tb_iot_event_arbiter.sv
module tb_iot_event_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze;
  logic [3:0] req_valid;
  logic [3:0] req_dir;

  logic [3:0] a_rdy, b_rdy;
  logic       a_chg, b_chg, a_on, b_on, a_rej, b_rej, a_bsy, b_bsy;
  logic [1:0] a_gid, b_gid;
  logic [7:0] a_cnt, b_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  iot_event_arbiter #(.ID_W(2), .MAX_DEVICES(255)) u_big (
    .clk(clk), .rst(rst), .freeze(freeze),
    .req_valid(req_valid), .req_dir(req_dir), .req_ready(a_rdy),
    .change(a_chg), .on_off(a_on), .grant_id(a_gid), .reject(a_rej),
    .active_count(a_cnt), .busy(a_bsy)
  );

  iot_event_arbiter #(.ID_W(2), .MAX_DEVICES(3)) u_sat (
    .clk(clk), .rst(rst), .freeze(freeze),
    .req_valid(req_valid), .req_dir(req_dir), .req_ready(b_rdy),
    .change(b_chg), .on_off(b_on), .grant_id(b_gid), .reject(b_rej),
    .active_count(b_cnt), .busy(b_bsy)
  );

  // Reference model, one slot per instance.
  int   mx[2] = '{255, 3};
  logic m_pend[2][4];
  logic m_dir[2][4];
  int   m_last[2];
  int   m_cnt[2];
  int   m_gid[2];
  logic m_chg[2], m_on[2], m_rej[2];
  logic model_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k);
    int w;
    w = -1;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_pend[k][i] = 1'b0;
        m_dir[k][i]  = 1'b0;
      end
      m_last[k] = 3;
      m_gid[k]  = 0;
      m_cnt[k]  = 0;
      m_chg[k]  = 1'b0;
      m_rej[k]  = 1'b0;
      m_on[k]   = 1'b1;
    end else begin
      if (!freeze) begin
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 4; i++)
          if (w < 0 && m_pend[k][i]) w = i;
`else
        for (int j = 1; j <= 4; j++)
          if (w < 0 && m_pend[k][(m_last[k] + j) % 4]) w = (m_last[k] + j) % 4;
`endif
      end
      for (int i = 0; i < 4; i++) begin
        if (req_valid[i] && !m_pend[k][i]) begin
          m_pend[k][i] = 1'b1;
          m_dir[k][i]  = req_dir[i];
        end
      end
      m_chg[k] = 1'b0;
      m_rej[k] = 1'b0;
      if (w >= 0) begin
        m_pend[k][w] = 1'b0;
        m_last[k]    = w;
        m_gid[k]     = w;
        if ((m_dir[k][w] && m_cnt[k] == mx[k]) || (!m_dir[k][w] && m_cnt[k] == 0)) begin
          m_rej[k] = 1'b1;
        end else begin
          m_chg[k] = 1'b1;
          m_on[k]  = m_dir[k][w];
          m_cnt[k] = m_dir[k][w] ? m_cnt[k] + 1 : m_cnt[k] - 1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
    if (rst) model_ok = 1'b1;
  end

  task automatic cmp_inst(input int k, input logic chg, input logic on, input logic [1:0] gid,
                          input logic rej, input logic [7:0] cnt, input logic [3:0] rdy,
                          input logic bsy);
    logic [3:0] erdy;
    for (int i = 0; i < 4; i++) erdy[i] = ~m_pend[k][i];
    check($sformatf("change[%0d]", k), 32'(chg), 32'(m_chg[k]));
    check($sformatf("reject[%0d]", k), 32'(rej), 32'(m_rej[k]));
    check($sformatf("on_off[%0d]", k), 32'(on), 32'(m_on[k]));
    check($sformatf("grant_id[%0d]", k), 32'(gid), 32'(m_gid[k]));
    check($sformatf("active_count[%0d]", k), 32'(cnt), 32'(m_cnt[k]));
    check($sformatf("req_ready[%0d]", k), 32'(rdy), 32'(erdy));
    check($sformatf("busy[%0d]", k), 32'(bsy), 32'(|erdy != 1'b1 || erdy != 4'hf));
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      cmp_inst(0, a_chg, a_on, a_gid, a_rej, a_cnt, a_rdy, a_bsy);
      cmp_inst(1, b_chg, b_on, b_gid, b_rej, b_cnt, b_rdy, b_bsy);
    end
  end

  initial begin
    rst       = 1'b1;
    freeze    = 1'b0;
    req_valid = '0;
    req_dir   = '0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_change", 32'(a_chg), 32'd0);
    check("rst_on_off", 32'(a_on), 32'd1);
    check("rst_count", 32'(a_cnt), 32'd0);
    check("rst_ready", 32'(a_rdy), 32'hf);
    check("rst_busy", 32'(a_bsy), 32'd0);

    // All four connect together: grants 0..3, saturating instance rejects the 4th
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_dir   = 4'b1111;
    @(negedge clk);
    req_valid = '0;
    check("rr_busy", 32'(a_bsy), 32'd1);
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check("rr_gid", 32'(a_gid), 32'(g));
      check("rr_change", 32'(a_chg), 32'd1);
      check("sat_change", 32'(b_chg), (g < 3) ? 32'd1 : 32'd0);
      check("sat_reject", 32'(b_rej), (g < 3) ? 32'd0 : 32'd1);
    end
    check("rr_count", 32'(a_cnt), 32'd4);
    check("sat_count", 32'(b_cnt), 32'd3);

    // Pointer wrap: after grant to 3, requesters 0 and 3 together -> 0 then 3
    req_valid = 4'b1001;
    req_dir   = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("wrap_gid0", 32'(a_gid), 32'd0);
    check("wrap_count5", 32'(a_cnt), 32'd5);
    @(negedge clk);
    check("wrap_gid3", 32'(a_gid), 32'd3);
    check("wrap_on_off", 32'(a_on), 32'd0);
    check("wrap_count4", 32'(a_cnt), 32'd4);

    // Freeze holds events on 1 and 2, release grants 1 then 2
    freeze    = 1'b1;
    req_valid = 4'b0110;
    req_dir   = 4'b0110;
    @(negedge clk);
    req_valid = '0;
    check("frz_change", 32'(a_chg), 32'd0);
    check("frz_busy", 32'(a_bsy), 32'd1);
    check("frz_ready", 32'(a_rdy), 32'b1001);
    @(negedge clk);
    check("frz_change2", 32'(a_chg), 32'd0);
    freeze = 1'b0;
    @(negedge clk);
    check("unfrz_gid1", 32'(a_gid), 32'd1);
    check("unfrz_change", 32'(a_chg), 32'd1);
    @(negedge clk);
    check("unfrz_gid2", 32'(a_gid), 32'd2);
    check("unfrz_count", 32'(a_cnt), 32'd6);

    req_valid = 4'b0001;
    req_dir   = 4'b0000;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("disc_count", 32'(a_cnt), 32'd5);

    // Reset mid-stream with three events pending and count 5
    freeze    = 1'b1;
    req_valid = 4'b0111;
    req_dir   = 4'b0111;
    @(negedge clk);
    req_valid = '0;
    check("mid_busy", 32'(a_bsy), 32'd1);
    check("mid_count", 32'(a_cnt), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    freeze = 1'b0;
    check("mid_rst_busy", 32'(a_bsy), 32'd0);
    check("mid_rst_count", 32'(a_cnt), 32'd0);
    @(negedge clk);
    check("mid_rst_change", 32'(a_chg), 32'd0);

    // Disconnect at count 0 is refused
    req_valid = 4'b0001;
    req_dir   = 4'b0000;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    check("under_reject", 32'(a_rej), 32'd1);
    check("under_change", 32'(a_chg), 32'd0);
    check("under_reject_sat", 32'(b_rej), 32'd1);
    check("under_count", 32'(a_cnt), 32'd0);

    // Random phase 1: connect-biased, drives the big instance toward saturation
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
        req_dir[i]   = ($urandom_range(0, 3) != 0);
      end
      freeze = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    // Random phase 2: balanced directions, occasional reset and freeze
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i] = ($urandom_range(0, 1) != 0);
        req_dir[i]   = ($urandom_range(0, 1) != 0);
      end
      freeze = ($urandom_range(0, 4) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst       = 1'b0;
    req_valid = '0;
    freeze    = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
